hazard_stall_ctrl: RTL and testbench

Pipeline interlock controller for the 5-stage MIPS pipeline. It works alongside the forwarding unit and covers the hazards that forwarding cannot resolve: load-use, branch-operand-in-decode and data-memory wait states. It drives the PC and pipeline-register write enables and flushes, tracks the active stall cause in a small FSM, and watchdogs memory waits.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/sat_counter.sv | 22 ++
 rtl/hazard_stall_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline interlock: stall cause / FSM state encoding
// and the hard-wired zero register.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDUSE   = 2'b01,
        BRSTALL = 2'b10,
        MEMWAIT = 2'b11
    } cause_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A producer in a later stage collides with the ID operands it feeds.
    function automatic logic src_hit(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
        return (rd != REG_ZERO) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for the memory-wait
// watchdog and the performance counters.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: load-use, branch-operand and data-memory-wait stalls.
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       RS_ADDR,
    input  logic [4:0]       RT_ADDR,
    input  logic             ID_Uses_RT,
    input  logic             ID_Branch,
    input  logic             Branch_Taken,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_RD,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_RD,
    input  logic             Mem_Req,
    input  logic             Mem_Ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MEM_WB_Flush,
    output logic [1:0]       Stall_Cause,
    output logic             Mem_Timeout,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TMO_LAST = WW'(MEM_TIMEOUT - 1);

    cause_e        state_q, state_d;
    logic          is_mem;
    logic [WW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // Next state is simply this cycle's cause; control outputs never look at state_q.
    always_comb begin
        state_d      = RUN;
        is_mem       = 1'b0;
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        MEM_WB_Flush = 1'b0;
        if (rst_n) begin
            if (Mem_Req && !Mem_Ready)
                state_d = MEMWAIT;
            else if (ID_EX_MemRead && src_hit(ID_EX_RD, RS_ADDR, RT_ADDR, ID_Uses_RT))
                state_d = LDUSE;
            else if (ID_Branch &&
                     ((ID_EX_RegWrite && src_hit(ID_EX_RD, RS_ADDR, RT_ADDR, ID_Uses_RT)) ||
                      (EX_MEM_MemRead && src_hit(EX_MEM_RD, RS_ADDR, RT_ADDR, ID_Uses_RT))))
                state_d = BRSTALL;

            unique case (state_d)
                MEMWAIT: begin
                    is_mem       = 1'b1;
                    MEM_WB_Flush = 1'b1;
                end
                LDUSE, BRSTALL: begin
                    ID_EX_Write  = 1'b1;
                    EX_MEM_Write = 1'b1;
                    ID_EX_Flush  = 1'b1;
                end
                default: begin
                    PC_Write     = 1'b1;
                    IF_ID_Write  = 1'b1;
                    ID_EX_Write  = 1'b1;
                    EX_MEM_Write = 1'b1;
                    IF_ID_Flush  = Branch_Taken;
                end
            endcase
        end
    end

    assign Stall_Cause = state_q;

    sat_counter #(.W(WW)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!is_mem),
        .inc   (is_mem),
        .cnt   (wait_cnt)
    );

    // Set on the same edge that completes the MEM_TIMEOUT-th wait cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            Mem_Timeout <= 1'b0;
        else if (is_mem && (wait_cnt >= TMO_LAST))
            Mem_Timeout <= 1'b1;
    end

`ifdef HAZARD_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (state_d != RUN),
        .cnt   (Stall_Cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (IF_ID_Flush),
        .cnt   (Flush_Cnt)
    );
`else
    assign Stall_Cnt = '0;
    assign Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: driver pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;

    localparam int MT    = 4;
    localparam int CW    = 4;
    localparam int WMAX  = (1 << $clog2(MT + 1)) - 1;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct {
        logic       rst_n;
        logic [4:0] rs, rt;
        logic       uses_rt, br, taken;
        logic       idex_mr, idex_rw;
        logic [4:0] idex_rd;
        logic       exmem_mr;
        logic [4:0] exmem_rd;
        logic       req, rdy;
    } stim_t;

    typedef struct {
        logic [6:0] ctl;   // {pc, ifid_we, idex_we, exmem_we, ifid_fl, idex_fl, memwb_fl}
        int         cause;
        int         tmo;
        int         scnt;
        int         fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] RS_ADDR, RT_ADDR, ID_EX_RD, EX_MEM_RD;
    logic ID_Uses_RT, ID_Branch, Branch_Taken, ID_EX_MemRead, ID_EX_RegWrite;
    logic EX_MEM_MemRead, Mem_Req, Mem_Ready;
    logic PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
    logic IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, Mem_Timeout;
    logic [1:0] Stall_Cause;
    logic [CW-1:0] Stall_Cnt, Flush_Cnt;

    hazard_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .RS_ADDR(RS_ADDR), .RT_ADDR(RT_ADDR), .ID_Uses_RT(ID_Uses_RT),
        .ID_Branch(ID_Branch), .Branch_Taken(Branch_Taken),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_RD(ID_EX_RD),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_RD(EX_MEM_RD),
        .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
        .EX_MEM_Write(EX_MEM_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
        .MEM_WB_Flush(MEM_WB_Flush), .Stall_Cause(Stall_Cause), .Mem_Timeout(Mem_Timeout),
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference state as seen after the most recent clock edge.
    int m_cause = 0, m_tmo = 0, m_wait = 0, m_scnt = 0, m_fcnt = 0;

    function automatic bit hit(input logic [4:0] rd, input stim_t s);
        return rd != 0 && (rd == s.rs || (s.uses_rt && rd == s.rt));
    endfunction

    task automatic cycle(input stim_t s);
        exp_t e;
        int   c;
        bit   fl;
        @(posedge clk);
        #1;
        rst_n = s.rst_n; RS_ADDR = s.rs; RT_ADDR = s.rt; ID_Uses_RT = s.uses_rt;
        ID_Branch = s.br; Branch_Taken = s.taken; ID_EX_MemRead = s.idex_mr;
        ID_EX_RegWrite = s.idex_rw; ID_EX_RD = s.idex_rd; EX_MEM_MemRead = s.exmem_mr;
        EX_MEM_RD = s.exmem_rd; Mem_Req = s.req; Mem_Ready = s.rdy;

        if (s.req && !s.rdy)                         c = 3;
        else if (s.idex_mr && hit(s.idex_rd, s))     c = 1;
        else if (s.br && ((s.idex_rw && hit(s.idex_rd, s)) ||
                          (s.exmem_mr && hit(s.exmem_rd, s)))) c = 2;
        else                                         c = 0;
        fl = (c == 0) && s.taken;

        if (!s.rst_n) begin
            m_cause = 0; m_tmo = 0; m_wait = 0; m_scnt = 0; m_fcnt = 0;
            e.ctl = 7'b0;
        end else begin
            case (c)
                3:       e.ctl = 7'b0000001;
                1, 2:    e.ctl = 7'b0011010;
                default: e.ctl = {6'b111100, 1'b0} | (fl ? 7'b0000100 : 7'b0);
            endcase
        end
        e.cause = m_cause; e.tmo = m_tmo; e.scnt = m_scnt; e.fcnt = m_fcnt;
        q.push_back(e);

        if (s.rst_n) begin
            m_cause = c;
            if (c == 3) begin
                if (m_wait + 1 >= MT) m_tmo = 1;
                m_wait = (m_wait < WMAX) ? m_wait + 1 : WMAX;
            end else begin
                m_wait = 0;
            end
`ifdef HAZARD_PERF_EN
            if (c != 0 && m_scnt < CMAX) m_scnt++;
            if (fl && m_fcnt < CMAX) m_fcnt++;
`endif
        end
    endtask

    task automatic chk(input string name, input int act, input int want);
        if (act != want) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                chk("ctl", int'({PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                                 IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush}), int'(e.ctl));
                chk("stall_cause", int'(Stall_Cause), e.cause);
                chk("mem_timeout", int'(Mem_Timeout), e.tmo);
                chk("stall_cnt", int'(Stall_Cnt), e.scnt);
                chk("flush_cnt", int'(Flush_Cnt), e.fcnt);
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1; s.rs = 1; s.rt = 2; s.uses_rt = 1; s.br = 0; s.taken = 0;
        s.idex_mr = 0; s.idex_rw = 0; s.idex_rd = 0; s.exmem_mr = 0; s.exmem_rd = 0;
        s.req = 0; s.rdy = 0;
        return s;
    endfunction

    initial begin
        stim_t s;
        int    guard;
        rst_n = 0; RS_ADDR = 0; RT_ADDR = 0; ID_Uses_RT = 0; ID_Branch = 0;
        Branch_Taken = 0; ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_RD = 0;
        EX_MEM_MemRead = 0; EX_MEM_RD = 0; Mem_Req = 0; Mem_Ready = 0;

        s = idle(); s.rst_n = 0; s.req = 1; cycle(s); cycle(s);
        s = idle(); cycle(s);

        // load-use on r5, then advance
        s = idle(); s.idex_mr = 1; s.idex_rd = 5; s.rs = 5; cycle(s);
        s = idle(); cycle(s);
        // load into r0 never stalls
        s = idle(); s.idex_mr = 1; s.idex_rd = 0; s.rs = 0; s.rt = 0; cycle(s);
        // lw r3 ; beq r3 : two BR stalls, then taken redirect
        s = idle(); s.br = 1; s.rs = 3; s.taken = 1; s.idex_rw = 1; s.idex_rd = 3; cycle(s);
        s = idle(); s.br = 1; s.rs = 3; s.taken = 1; s.exmem_mr = 1; s.exmem_rd = 3; cycle(s);
        s = idle(); s.br = 1; s.rs = 3; s.taken = 1; cycle(s);
        s = idle(); cycle(s);
        // memory wait overrides a present load-use
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.idex_mr = 1; s.idex_rd = 2; s.req = 1; s.taken = 1; cycle(s);
        end
        s = idle(); s.idex_mr = 1; s.idex_rd = 2; s.req = 1; s.rdy = 1; cycle(s);
        s = idle(); s.rdy = 1; cycle(s);
        // watchdog: 6 waits, then ready, sticky until reset
        for (int i = 0; i < 6; i++) begin s = idle(); s.req = 1; cycle(s); end
        s = idle(); s.req = 1; s.rdy = 1; cycle(s);
        s = idle(); cycle(s); cycle(s);
        s = idle(); s.rst_n = 0; s.req = 1; cycle(s);
        s = idle(); cycle(s);
        // 20 stall cycles drive the counter to saturation when enabled
        for (int i = 0; i < 20; i++) begin
            s = idle(); s.idex_mr = 1; s.idex_rd = 7; s.rs = 7; cycle(s);
        end
        s = idle(); s.taken = 1; cycle(s); cycle(s);

        // random traffic with a narrow register range to provoke collisions
        for (int i = 0; i < 600; i++) begin
            s.rst_n    = ($urandom_range(0, 99) != 0);
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.uses_rt  = 1'($urandom);
            s.br       = 1'($urandom);
            s.taken    = 1'($urandom);
            s.idex_mr  = ($urandom_range(0, 3) == 0);
            s.idex_rw  = 1'($urandom);
            s.idex_rd  = 5'($urandom_range(0, 3));
            s.exmem_mr = 1'($urandom);
            s.exmem_rd = 5'($urandom_range(0, 3));
            s.req      = ($urandom_range(0, 2) != 0);
            s.rdy      = ($urandom_range(0, 3) == 0);
            cycle(s);
        end

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
